// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: runs one wide ADD/XOR/PASS(/SUB) operation through a shared 4-bit ALU, one nibble per cycle, LSB first.
//   Optional macro: ALU_NIBBLE_SEQ_SUB_EN enables op=11 as SUB (opa - opb); otherwise op=11 behaves as ADD.
//   Ports: clk, rst_n (sync, active-low); start/op/opa/opb/cin request (captured in IDLE);
//          busy/done handshake; result/cout/zero of last completed op;
//          alu_a/alu_b/alu_sel/alu_cin drive the ALU, alu_out/alu_cout come back combinationally.
module alu_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [4*NIBBLES-1:0]   opa,
    input  logic [4*NIBBLES-1:0]   opb,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   zero,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [2:0]             alu_sel,
    output logic                   alu_cin,
    input  logic [3:0]             alu_out,
    input  logic                   alu_cout
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [W-1:0]    a_q, b_q, work_q, work_d, result_q;
    logic [1:0]      op_q;
    logic            cin_q, carry_q, carry_d, cout_q, zero_q, busy_q, done_q;
    logic            run, arith, cin0;
    logic [3:0]      a_nib, b_nib, b_eff;

    // op 00 and 11 both use the adder path (11 is SUB or an alias of ADD)
    assign arith = op_q[1] == op_q[0];
    assign a_nib = a_q[4*idx_q +: 4];
    assign b_nib = b_q[4*idx_q +: 4];

`ifdef ALU_NIBBLE_SEQ_SUB_EN
    // two's-complement subtract: invert B and inject 1 into the first nibble
    assign b_eff = op_q == 2'b11 ? ~b_nib : b_nib;
    assign cin0  = op_q == 2'b11 ? 1'b1 : cin_q;
`else
    assign b_eff = b_nib;
    assign cin0  = cin_q;
`endif

    always_comb begin
        run     = state_q == RUN;
        alu_a   = run ? a_nib : 4'h0;
        alu_b   = run ? b_eff : 4'h0;
        alu_sel = run && arith ? 3'b010 : run && op_q == 2'b01 ? 3'b100 : 3'b111;
        alu_cin = run && arith ? (idx_q == '0 ? cin0 : carry_q) : 1'b0;
        carry_d = arith & alu_cout;
        work_d  = work_q;
        work_d[4*idx_q +: 4] = alu_out;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cin_q    <= 1'b0;
            work_q   <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    a_q     <= opa;
                    b_q     <= opb;
                    op_q    <= op;
                    cin_q   <= cin;
                    idx_q   <= '0;
                    carry_q <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= RUN;
                end
                RUN: begin
                    work_q  <= work_d;
                    carry_q <= carry_d;
                    if (idx_q == IW'(NIBBLES - 1)) begin
                        result_q <= work_d;
                        cout_q   <= carry_d;
                        zero_q   <= work_d == '0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;
endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq: directed checks of alu_nibble_seq (NIBBLES=4) against a behavioural 4-bit ALU.
module tb_alu_nibble_seq;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] opa = '0, opb = '0;
    logic        busy, done, cout, zero, alu_cin, alu_cout;
    logic [15:0] result;
    logic [3:0]  alu_a, alu_b, alu_out;
    logic [2:0]  alu_sel;
    logic [4:0]  sum;
    int          n_chk = 0, n_fail = 0;
    int          done_at, done_cnt, busy_cnt;
    logic [3:0]  cin_seq;
    logic        sel_ok;
    logic [2:0]  idle_sel;
    logic [15:0] dmask;

    alu_nibble_seq #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    // reference HC4e ALU: 010 add, 100 xor, 111 pass A
    always_comb begin
        sum      = {1'b0, alu_a} + {1'b0, alu_b} + {4'h0, alu_cin};
        alu_out  = alu_sel == 3'b010 ? sum[3:0] : alu_sel == 3'b100 ? alu_a ^ alu_b : alu_a;
        alu_cout = alu_sel == 3'b010 ? sum[4] : 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // launch one op from a negedge and watch 8 cycles after the accepting edge
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input logic c);
        op = o; opa = a; opb = b; cin = c; start = 1'b1;
        done_at = 0; done_cnt = 0; busy_cnt = 0; cin_seq = '0; sel_ok = 1'b1; idle_sel = '0;
        for (int c2 = 1; c2 <= 8; c2++) begin
            @(negedge clk);
            if (c2 == 1) start = 1'b0;
            if (done) begin done_cnt++; if (done_at == 0) done_at = c2; end
            if (busy) busy_cnt++;
            if (c2 <= 4) begin
                cin_seq[c2-1] = alu_cin;
                if (alu_sel !== (o == 2'b01 ? 3'b100 : o == 2'b10 ? 3'b111 : 3'b010)) sel_ok = 1'b0;
            end
            if (c2 == 7) idle_sel = alu_sel;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_zero", zero, 1);
        chk("rst_alu_sel", alu_sel, 3'b111);
        chk("rst_alu_a", alu_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b00, 16'h1234, 16'h0FFF, 1'b0);
        chk("add1_result", result, 16'h2233);
        chk("add1_cout", cout, 0);
        chk("add1_zero", zero, 0);
        chk("add1_done_at", done_at, 5);
        chk("add1_done_cnt", done_cnt, 1);
        chk("add1_busy_cnt", busy_cnt, 5);

        run_op(2'b00, 16'hFFFF, 16'h0001, 1'b0);
        chk("add2_result", result, 16'h0000);
        chk("add2_cout", cout, 1);
        chk("add2_zero", zero, 1);
        chk("add2_cin_seq", cin_seq, 4'b1110);

        run_op(2'b00, 16'h00FF, 16'h0000, 1'b1);
        chk("add3_cin_result", result, 16'h0100);
        chk("add3_cin_first", cin_seq, 4'b0111);

        run_op(2'b01, 16'hCAFE, 16'hCAFE, 1'b1);
        chk("xor_result", result, 16'h0000);
        chk("xor_zero", zero, 1);
        chk("xor_cout", cout, 0);
        chk("xor_sel_run", sel_ok, 1);
        chk("xor_sel_idle", idle_sel, 3'b111);
        chk("xor_cin_seq", cin_seq, 4'b0000);

        run_op(2'b01, 16'h0F0F, 16'h00FF, 1'b0);
        chk("xor2_result", result, 16'h0FF0);

        // PASS with start held 10 cycles: accepted at c=0 and c=6, done at c=5 and c=11
        op = 2'b10; opa = 16'hA5A5; opb = 16'h1234; cin = 1'b0; start = 1'b1; dmask = '0;
        for (int c3 = 1; c3 <= 14; c3++) begin
            @(negedge clk);
            if (c3 == 1) begin opa = 16'hFFFF; opb = 16'h0000; end
            if (c3 == 5) opa = 16'hA5A5;
            if (c3 == 8) opa = 16'h0000;
            if (c3 == 10) start = 1'b0;
            dmask[c3] = done;
            if (c3 == 6) chk("pass1_result", result, 16'hA5A5);
            if (c3 == 12) chk("pass2_result", result, 16'hA5A5);
        end
        chk("pass_done_mask", dmask, 16'h0820);
        chk("pass_cout", cout, 0);
        chk("pass_zero", zero, 0);

        // reset during RUN nibble 2
        op = 2'b00; opa = 16'h1111; opb = 16'h2222; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_busy_before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_result", result, 0);
        chk("rstmid_zero", zero, 1);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'b00, 16'h0001, 16'h0001, 1'b0);
        chk("post_rst_result", result, 16'h0002);
        chk("post_rst_done_at", done_at, 5);

`ifdef ALU_NIBBLE_SEQ_SUB_EN
        run_op(2'b11, 16'h1000, 16'h0001, 1'b0);
        chk("sub1_result", result, 16'h0FFF);
        chk("sub1_cout", cout, 1);
        run_op(2'b11, 16'h0000, 16'h0001, 1'b0);
        chk("sub2_result", result, 16'hFFFF);
        chk("sub2_cout", cout, 0);
`else
        run_op(2'b11, 16'h1000, 16'h0001, 1'b0);
        chk("op11_add_result", result, 16'h1001);
        chk("op11_add_cout", cout, 0);
        run_op(2'b11, 16'h000F, 16'h0000, 1'b1);
        chk("op11_add_cin", result, 16'h0010);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
- Multi-nibble operation sequencer for the 4-bit HC4e ALU.
- Accepts one wide operation (NIBBLES×4 bits) through a start/busy/done handshake.
- Drives the shared 4-bit ALU one nibble per cycle, LSB first, and chains the carry through a carry register.
- Sits between the HC4e control unit and the ALU instance; presents a wide result with carry and zero flags.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- op  in  2  00 ADD, 01 XOR, 10 PASS (result = opa), 11 SUB (see Optional Feature)
- opa  in  W  operand A; captured when start is accepted
- opb  in  W  operand B; captured when start is accepted
- cin  in  1  carry-in for ADD; captured when start is accepted
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle completion pulse
- result  out  W  result of the last completed operation
- cout  out  1  carry of the last completed operation
- zero  out  1  high when result == 0
- alu_a  out  4  to ALU in_A
- alu_b  out  4  to ALU in_B
- alu_sel  out  3  to ALU sel_in: ADD = 010, XOR = 100, PASS = 111
- alu_cin  out  1  to ALU carry_in
- alu_out  in  4  from ALU out (combinational)
- alu_cout  in  1  from ALU carry_out

Behaviour:
- Clock and reset: single clock domain (clk); reset is synchronous, active-low (rst_n), applied at the rising edge.
- Reset values: state = IDLE; busy = 0; done = 0; result = 0; cout = 0; zero = 1; nibble index = 0; carry register = 0.
- FSM states and transitions:
  - IDLE: if start = 1, capture opa, opb, op and cin, then go to RUN with index = 0.
  - RUN: stays NIBBLES cycles; index increments each cycle; when index = NIBBLES-1, go to DONE.
  - DONE: lasts one cycle with done = 1, then returns to IDLE.
- Latency:
  - start sampled at edge T0; done = 1 during the cycle after edge T0+NIBBLES.
  - Back-to-back operations: next start accepted in the first IDLE cycle after DONE, so one operation takes NIBBLES+2 cycles.
- start while busy (RUN or DONE) is ignored; a held start is not queued.
- RUN cycle k:
  - alu_a = captured opa[4k+3:4k]; alu_b = captured opb[4k+3:4k]; alu_sel per op.
  - At the clock edge: working nibble k <= alu_out; carry register <= alu_cout.
- Carry chain:
  - ADD: alu_cin = captured cin for k = 0, otherwise the carry register.
  - XOR and PASS: alu_cin = 0; carry register is forced to 0.
- RUN→DONE edge:
  - result <= working register including the final nibble.
  - cout <= final carry (always 0 for XOR and PASS).
  - zero <= (result == 0).
- result, cout and zero hold their values until the next RUN→DONE edge and do not change during a new operation.
- IDLE and DONE drive fixed, deterministic ALU inputs: alu_a = 0, alu_b = 0, alu_sel = 111, alu_cin = 0.
- The ALU is combinational; alu_out is sampled in the same cycle the operands are driven, with no wait states.
- Reset mid-operation: rst_n low in any state returns to reset values at the next edge. The operation in progress is discarded and done is not asserted.
- NIBBLES = 1: RUN lasts exactly one cycle; the rules above are unchanged.

Optional Feature:
- Macro: ALU_NIBBLE_SEQ_SUB_EN.
- Defined: op = 11 is SUB = opa - opb.
  - alu_sel = 010; alu_b = ~opb nibble; alu_cin = 1 for k = 0 (input cin ignored), then the carry register.
  - cout = 1 means no borrow.
- Not defined: op = 11 decodes as ADD, behaving exactly as op = 00 including use of cin; no inversion logic is synthesized.

Test Plan (NIBBLES = 4):
- ADD 0x1234 + 0x0FFF, cin = 0 -> result 0x2233, cout 0, zero 0; done high exactly one cycle, in the cycle after edge T0+4; busy high for 5 cycles.
- ADD 0xFFFF + 0x0001, cin = 0 -> result 0x0000, cout 1, zero 1; alu_cin per RUN cycle = 0, 1, 1, 1.
- XOR 0xCAFE ^ 0xCAFE -> result 0x0000, zero 1, cout 0; alu_sel = 100 in all RUN cycles and 111 in IDLE.
- PASS opa = 0xA5A5 with start held high for 10 cycles -> one done per 6 cycles, each result = 0xA5A5; operand changes while busy do not affect result.
- ADD 0x1111 + 0x2222 with rst_n low during RUN nibble 2 -> next cycle busy 0, done 0, result 0x0000, zero 1; a following ADD 0x0001 + 0x0001 gives 0x0002.
- SUB:
  - With macro: 0x1000 - 0x0001 -> 0x0FFF, cout 1; 0x0000 - 0x0001 -> 0xFFFF, cout 0.
  - Without macro: op = 11, 0x1000, 0x0001, cin = 0 -> 0x1001.
